// File: rtl/sr_latch_pkg.sv
// Shared types for the SR latch bank write controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sr_latch_pkg;

  // Number of latch bits in the bank; the controller's WIDTH defaults to this.
  localparam int LAT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  // Per-bit set/reset command pair driven onto the bank.
  typedef struct packed {
    logic [LAT_WIDTH-1:0] s;
    logic [LAT_WIDTH-1:0] r;
  } cmd_t;

  // Phase counter width: enough to hold the longest timed phase.
  function automatic int phase_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter timing the SETUP, PULSE and HOLD phases.
// Latency: load takes effect at the next edge; last is combinational from the count.
// Backpressure: none; counts every cycle it is not being loaded.
// Ports: clk, rst_n (sync, active-low), load + load_val (phase entry),
//        last (high in the final cycle of the current phase).
module sr_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] cnt;

  // Saturates at zero so the counter idles quietly between phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/sr_latch_writer.sv
// Write controller for a bank of gated SR latches: sequences S/R setup, gate pulse, hold, then verifies Q/P.
// Latency: handshake cycle to DONE = SETUP_CYC+PULSE_CYC+HOLD_CYC+2 cycles; a new word may be taken in the DONE cycle.
// Backpressure: IN_READY is high only in IDLE; words are held off for the whole sequence.
// Ports: CLK/RST_N (sync, active-low); IN_VALID/IN_READY/IN_DATA target word; CLR_ERR clears sticky error;
//        LAT_S/LAT_R/LAT_G drive the bank; LAT_Q/LAT_P read it back; DONE pulse, ERR sticky, ERR_MASK failing bits.
module sr_latch_writer
  import sr_latch_pkg::*;
#(
  parameter int WIDTH     = LAT_WIDTH,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] LAT_S,
  output logic [WIDTH-1:0] LAT_R,
  output logic             LAT_G,
  input  logic [WIDTH-1:0] LAT_Q,
  input  logic [WIDTH-1:0] LAT_P,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] ERR_MASK
);

  localparam int CW = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             phase_last;
  logic             tmr_load;
  logic [CW-1:0]    tmr_val;

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] shadow;
  logic             shadow_valid;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] fail_mask;
  cmd_t             cmd_nxt;
  cmd_t             cmd_q;
  logic             gate_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] err_mask_q;

  assign accept = IN_VALID & IN_READY;

  // Without a trusted shadow every bit is forced; otherwise only changed bits are commanded.
  assign diff      = shadow_valid ? (IN_DATA ^ shadow) : {WIDTH{1'b1}};
  assign cmd_nxt.s = diff & IN_DATA;
  assign cmd_nxt.r = diff & ~IN_DATA;

  // A bit fails if Q missed the target or P is not the complement of Q.
  assign fail_mask = (LAT_Q ^ target) | ~(LAT_P ^ LAT_Q);

  sr_phase_timer #(.CW(CW)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (phase_last)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)     state_nxt = ST_SETUP;
      ST_SETUP: if (phase_last) state_nxt = ST_PULSE;
      ST_PULSE: if (phase_last) state_nxt = ST_HOLD;
      ST_HOLD:  if (phase_last) state_nxt = ST_CHECK;
      ST_CHECK:                 state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: ready, and timer reload on entry to each timed phase.
  always_comb begin
    IN_READY = (state == ST_IDLE);
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_nxt != state) begin
      case (state_nxt)
        ST_SETUP: begin tmr_load = 1'b1; tmr_val = CW'(SETUP_CYC); end
        ST_PULSE: begin tmr_load = 1'b1; tmr_val = CW'(PULSE_CYC); end
        ST_HOLD:  begin tmr_load = 1'b1; tmr_val = CW'(HOLD_CYC);  end
        default:  ;
      endcase
    end
  end

  // Registered bank drive and result tracking. S/R are latched at acceptance and
  // only cleared on entry to CHECK, so they cannot move while the gate is high.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      target       <= '0;
      cmd_q        <= '0;
      gate_q       <= 1'b0;
      done_q       <= 1'b0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      err_q        <= 1'b0;
      err_mask_q   <= '0;
    end else begin
      gate_q <= (state_nxt == ST_PULSE);
      done_q <= (state == ST_CHECK);

      if (accept) begin
        target <= IN_DATA;
        cmd_q  <= cmd_nxt;
      end else if (state_nxt == ST_CHECK) begin
        cmd_q  <= '0;
      end

      if (state == ST_CHECK) begin
        shadow       <= LAT_Q;
        shadow_valid <= (fail_mask == '0);
      end

      // A failure recorded this cycle takes priority over a clear request.
      if ((state == ST_CHECK) && (fail_mask != '0)) begin
        err_q      <= 1'b1;
        err_mask_q <= fail_mask;
      end else if (CLR_ERR) begin
        err_q      <= 1'b0;
        err_mask_q <= '0;
      end
    end
  end

  assign LAT_S    = cmd_q.s;
  assign LAT_R    = cmd_q.r;
  assign LAT_G    = gate_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_MASK = err_mask_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Directed bench for sr_latch_writer with a behavioural latch bank and fault injection.
// Latency: checks handshake-to-DONE of 6 cycles and back-to-back acceptance every 6 cycles.
// Backpressure: drives IN_VALID continuously in one phase to exercise accept-on-DONE.
module tb_sr_latch_writer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] IN_DATA = '0;
  logic       CLR_ERR = 1'b0;
  logic [7:0] LAT_S, LAT_R, LAT_Q, LAT_P, ERR_MASK;
  logic       LAT_G, DONE, ERR;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural latch bank plus fault injection.
  logic [7:0] q_mdl = '0;
  logic [7:0] stuck0 = '0;
  logic [7:0] qp_eq = '0;

  always @(posedge CLK) if (LAT_G) q_mdl <= (q_mdl | LAT_S) & ~LAT_R;
  assign LAT_Q = q_mdl & ~stuck0;
  assign LAT_P = ~LAT_Q ^ qp_eq;

  always #5 CLK = ~CLK;

  sr_latch_writer dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .CLR_ERR(CLR_ERR), .LAT_S(LAT_S), .LAT_R(LAT_R),
    .LAT_G(LAT_G), .LAT_Q(LAT_Q), .LAT_P(LAT_P), .DONE(DONE), .ERR(ERR),
    .ERR_MASK(ERR_MASK)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Continuous invariants: S&R never both set; S/R frozen around the gate.
  logic       rst_q, g_prev;
  logic [7:0] s_prev, r_prev;
  always @(posedge CLK) rst_q <= RST_N;
  always @(negedge CLK) begin
    chk("s_and_r", {24'd0, LAT_S & LAT_R}, 32'd0);
    if (rst_q === 1'b1 && (LAT_G === 1'b1 || g_prev === 1'b1)) begin
      chk("s_stable_g", {24'd0, LAT_S}, {24'd0, s_prev});
      chk("r_stable_g", {24'd0, LAT_R}, {24'd0, r_prev});
    end
    g_prev = LAT_G;
    s_prev = LAT_S;
    r_prev = LAT_R;
  end

  // One transaction, called at a negedge while idle; returns at the DONE-cycle negedge.
  task automatic do_write(input string tag, input logic [7:0] d, input logic [7:0] es,
                          input logic [7:0] er, input int clr_at);
    int n, g, dc;
    logic [7:0] s1, r1;
    n = 0; g = 0; dc = 0; s1 = '0; r1 = '0;
    IN_DATA  = d;
    IN_VALID = 1'b1;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        IN_VALID = 1'b0;
        s1 = LAT_S;
        r1 = LAT_R;
      end
      CLR_ERR = (n == clr_at);
      if (LAT_G) g++;
      if ((LAT_S | LAT_R) != 8'h00) dc++;
    end while (!DONE && n < 20);
    CLR_ERR = 1'b0;
    chk({tag, "_s"}, {24'd0, s1}, {24'd0, es});
    chk({tag, "_r"}, {24'd0, r1}, {24'd0, er});
    chk({tag, "_lat"}, n, 6);
    chk({tag, "_gcyc"}, g, 2);
    chk({tag, "_drvcyc"}, dc, ((es | er) != 8'h00) ? 4 : 0);
    chk({tag, "_rdy_done"}, {31'd0, IN_READY}, 1);
  endtask

  logic [7:0] bw [3];
  logic [7:0] bs [3];
  logic [7:0] br [3];
  int         acc_cyc [3];
  int         idx, cyc;
  logic       acc;

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_s", {24'd0, LAT_S}, 0);
    chk("rst_r", {24'd0, LAT_R}, 0);
    chk("rst_g", {31'd0, LAT_G}, 0);
    chk("rst_done", {31'd0, DONE}, 0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_mask", {24'd0, ERR_MASK}, 0);
    chk("rst_rdy", {31'd0, IN_READY}, 1);
    RST_N = 1'b1;

    // First write forces every bit.
    do_write("w_a5", 8'hA5, 8'hA5, 8'h5A, 0);
    chk("a5_err", {31'd0, ERR}, 0);

    // Only bit 0 changes.
    do_write("w_a4", 8'hA4, 8'h00, 8'h01, 0);
    chk("a4_err", {31'd0, ERR}, 0);

    // Bit 3 stuck at 0.
    stuck0 = 8'h08;
    do_write("w_ff", 8'hFF, 8'h5B, 8'h00, 0);
    chk("stuck_err", {31'd0, ERR}, 1);
    chk("stuck_mask", {24'd0, ERR_MASK}, 32'h08);
    stuck0 = 8'h00;

    // Shadow invalid: all bits forced; success leaves sticky error untouched.
    do_write("w_ff2", 8'hFF, 8'hFF, 8'h00, 0);
    chk("ff2_err", {31'd0, ERR}, 1);
    chk("ff2_mask", {24'd0, ERR_MASK}, 32'h08);

    // Q==P on bit 7, clear requested in the failing cycle.
    qp_eq = 8'h80;
    do_write("w_7f", 8'h7F, 8'h00, 8'h80, 5);
    chk("qp_err", {31'd0, ERR}, 1);
    chk("qp_mask", {24'd0, ERR_MASK}, 32'h80);
    qp_eq = 8'h00;
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    chk("clr_err", {31'd0, ERR}, 0);
    chk("clr_mask", {24'd0, ERR_MASK}, 0);

    // Back-to-back with IN_VALID held high.
    bw[0] = 8'h01; bs[0] = 8'h01; br[0] = 8'hFE;
    bw[1] = 8'h02; bs[1] = 8'h02; br[1] = 8'h01;
    bw[2] = 8'h03; bs[2] = 8'h01; br[2] = 8'h00;
    for (int k = 0; k < 3; k++) acc_cyc[k] = 0;
    idx = 0;
    IN_DATA = bw[0];
    IN_VALID = 1'b1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      acc = IN_VALID & IN_READY;
      @(negedge CLK);
      if (acc && idx < 3) begin
        chk("b2b_s", {24'd0, LAT_S}, {24'd0, bs[idx]});
        chk("b2b_r", {24'd0, LAT_R}, {24'd0, br[idx]});
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) IN_DATA = bw[idx];
        else         IN_VALID = 1'b0;
      end
      if (DONE && IN_VALID) chk("b2b_rdy_on_done", {31'd0, IN_READY}, 1);
    end
    chk("b2b_count", idx, 3);
    chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 6);
    chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 6);
    chk("b2b_err", {31'd0, ERR}, 0);

    // Reset during PULSE.
    IN_DATA = 8'h55;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("pre_rst_g", {31'd0, LAT_G}, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_g", {31'd0, LAT_G}, 0);
    chk("midrst_s", {24'd0, LAT_S}, 0);
    chk("midrst_r", {24'd0, LAT_R}, 0);
    chk("midrst_rdy", {31'd0, IN_READY}, 1);
    chk("midrst_done", {31'd0, DONE}, 0);
    RST_N = 1'b1;

    // Shadow was invalidated by reset: every bit forced.
    do_write("w_post", 8'h03, 8'h03, 8'hFC, 0);
    chk("post_err", {31'd0, ERR}, 0);

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_latch_writer.md
Name: sr_latch_writer

Overview:
- Write-side controller for a bank of WIDTH gated SR latches with NAND-style outputs Q and P, where P is the complement of Q.
- Accepts a target word over a valid/ready handshake and drives per-bit S/R commands and a shared gate with programmable setup, pulse and hold timing.
- Reads back Q/P afterwards and flags any bit that did not land or is in an illegal output state.
- Sits between the register/control logic and the latch bank.

Parameters:
WIDTH, 8, number of latch bits driven.
SETUP_CYC, 1, cycles S/R are stable before the gate rises (>=1).
PULSE_CYC, 2, cycles the gate is held high (>=1).
HOLD_CYC, 1, cycles S/R stay stable after the gate falls (>=1).

Ports:
CLK  in  1  single clock; all logic on the rising edge.
RST_N  in  1  synchronous reset, active-low.
IN_VALID  in  1  target word offered.
IN_READY  out  1  controller can accept a word.
IN_DATA  in  WIDTH  target latch contents.
CLR_ERR  in  1  clears sticky ERR and ERR_MASK.
LAT_S  out  WIDTH  per-bit set command to the latch bank.
LAT_R  out  WIDTH  per-bit reset command to the latch bank.
LAT_G  out  1  shared latch gate (latch CLK).
LAT_Q  in  WIDTH  latch Q readback.
LAT_P  in  WIDTH  latch P (complement) readback.
DONE  out  1  one-cycle pulse when a transaction completes.
ERR  out  1  sticky error flag.
ERR_MASK  out  WIDTH  bits that failed in the most recent failing check.

Behaviour:
- Reset (RST_N=0 at an edge): state IDLE, LAT_S=LAT_R=0, LAT_G=0, DONE=0, ERR=0, ERR_MASK=0, shadow=0, shadow_valid=0, IN_READY=1 after the reset cycle.
- FSM states and transitions:
  - IDLE -> SETUP on IN_VALID & IN_READY.
  - SETUP lasts SETUP_CYC cycles -> PULSE.
  - PULSE lasts PULSE_CYC cycles -> HOLD.
  - HOLD lasts HOLD_CYC cycles -> CHECK.
  - CHECK lasts 1 cycle -> IDLE.
- IN_READY is 1 only in IDLE, including the DONE cycle, so back-to-back transactions are allowed.
- At acceptance, the target is registered and the per-bit commands are computed from diff = shadow_valid ? (target ^ shadow) : all-ones:
  - S[i] = diff[i] & target[i]
  - R[i] = diff[i] & ~target[i]
- LAT_S/LAT_R are registered. They are driven from the first SETUP cycle through the last HOLD cycle and are 0 in IDLE and CHECK. They never change while LAT_G=1.
- Invariant: LAT_S[i] & LAT_R[i] is never 1 for any bit in any cycle.
- LAT_G=1 exactly during PULSE cycles.
- CHECK samples LAT_Q/LAT_P. A bit fails if LAT_Q[i] != target[i] or LAT_P[i] != ~LAT_Q[i].
- Registered result at the CHECK->IDLE edge:
  - DONE=1 for one cycle.
  - shadow <= sampled LAT_Q.
  - shadow_valid <= (no failures).
  - On any failure: ERR <= 1 and ERR_MASK <= failing bits.
  - On success: ERR and ERR_MASK are unchanged.
- CLR_ERR clears ERR and ERR_MASK at the next edge. If a failure is recorded in the same cycle, the failure wins.
- A write equal to shadow (with shadow_valid=1) still runs the full sequence with all S/R=0 and re-verifies.
- Latency: acceptance edge to DONE high = SETUP_CYC+PULSE_CYC+HOLD_CYC+2 cycles (6 with defaults).
- Reset mid-transaction: immediate return to IDLE with all reset values. LAT_G and LAT_S/LAT_R drop at that edge. The next write forces all bits (shadow_valid=0).
- The phase counter is a down-counter of width clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). It is reloaded on each phase entry; the phase ends when the counter reaches 1.

Decomposition:
- Package sr_latch_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, CHECK);
  - a cmd struct {s, r} parameterised by WIDTH via localparam;
  - the counter-width function.
- One sub-module, sr_phase_timer: a loadable down-counter with a load value input and a last-cycle output, shared by the three timed phases.

Test Plan:
- Reset, then write 0xA5 with the model latch bank behaving correctly -> S=0xA5, R=0x5A driven for 4 cycles, G high for 2 cycles, DONE 6 cycles after acceptance, ERR=0.
- Then write 0xA4 -> only R[0]=1 with all other S/R=0, DONE after 6 cycles, shadow=0xA4.
- Model forces bit 3 stuck at 0, write 0xFF -> ERR=1, ERR_MASK=0x08; the next write 0xFF drives all eight S bits (shadow invalid).
- Model drives Q=P on bit 7 -> bit 7 flagged. Assert CLR_ERR in the same cycle as the failure -> ERR stays 1; assert CLR_ERR one cycle later -> ERR=0.
- Hold IN_VALID high continuously with words 0x01, 0x02, 0x03 -> accepted every 6 cycles, each acceptance coinciding with the prior DONE. Assertion: no cycle has S&R nonzero, and S/R are stable whenever G=1.
- Deassert RST_N during PULSE -> next edge gives G=0, S=R=0, IDLE, IN_READY=1; a subsequent write drives every bit.
